// File: rtl/seq_fsm_pkg.sv
// ---------------------------------------------------------------------------
// seq_fsm_pkg
// Shared definitions for the parametrised step sequencer:
//   DIR_UP / DIR_DOWN : encodings of the direction control and latch
//   width_of()        : bit width needed to hold values 0..n-1, never below 1
// ---------------------------------------------------------------------------
package seq_fsm_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // $clog2 returns 0 for n<=1; a zero-width counter is not legal, so clamp.
    function automatic int unsigned width_of(input int unsigned n);
        if (n < 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(n);
        end
    endfunction

endpackage

// File: rtl/seq_fsm_n_dwell.sv
// ---------------------------------------------------------------------------
// dwell_counter
// Counts the cycles spent in the current sequencer state.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (count -> 0)
//   clr  : synchronous clear, wins over en
//   en   : advance the count by one (wraps to 0 after DWELL-1)
//   step : combinational terminal-count flag (count == DWELL-1)
// ---------------------------------------------------------------------------
module dwell_counter
    import seq_fsm_pkg::*;
#(
    parameter int DWELL = 1,
    parameter int CW    = width_of(DWELL)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic step
);

    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear beats enable; wrap to zero at terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = {CW{1'b0}};
        end else if (en) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // With DWELL=1 the count is pinned at 0, so every enabled cycle steps.
    assign step = (cnt_q == CNT_LAST);

endmodule

// File: rtl/seq_fsm_n.sv
// ---------------------------------------------------------------------------
// seq_fsm_n
// N-state step sequencer with per-state dwell, up/down direction and
// one-shot or wrap mode. Drop-in superset of the three-state odd/even FSM.
// Ports:
//   clk, rst  : rising-edge clock, synchronous active-high reset
//   pause     : freeze state and dwell count
//   restart   : return to start state, latch dir/one_shot (beats pause)
//   dir       : 0 up, 1 down (sampled only on restart)
//   one_shot  : 1 halt at terminal, 0 wrap (sampled only on restart)
//   state     : current state 1..NUM_STATES
//   odd/even  : state parity decode
//   terminal  : state is the last one in the latched direction
//   wrap_p    : one-cycle pulse after a wrapping step
//   halted    : one-shot sequence finished
// All outputs decode registered state only.
// ---------------------------------------------------------------------------
module seq_fsm_n
    import seq_fsm_pkg::*;
#(
    parameter int NUM_STATES = 3,
    parameter int DWELL      = 1,
    parameter int SW         = width_of(NUM_STATES + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pause,
    input  logic          restart,
    input  logic          dir,
    input  logic          one_shot,
    output logic [SW-1:0] state,
    output logic          odd,
    output logic          even,
    output logic          terminal,
    output logic          wrap_p,
    output logic          halted
);

    localparam logic [SW-1:0] ST_FIRST = SW'(1);
    localparam logic [SW-1:0] ST_LAST  = SW'(NUM_STATES);

    logic [SW-1:0] state_q, state_d;
    logic          dir_q, dir_d;
    logic          one_shot_q, one_shot_d;
    logic          halted_q, halted_d;
    logic          wrap_q, wrap_d;

    logic          adv_s;
    logic          tc_s;
    logic          term_s;

    // The dwell counter only runs when nothing higher in priority is active.
    assign adv_s  = ~restart & ~pause & ~halted_q;

    assign term_s = (dir_q == DIR_DOWN) ? (state_q == ST_FIRST)
                                        : (state_q == ST_LAST);

    dwell_counter #(
        .DWELL (DWELL)
    ) u_dwell (
        .clk  (clk),
        .rst  (rst),
        .clr  (restart),
        .en   (adv_s),
        .step (tc_s)
    );

    // Next-state: restart > pause > halted > step event; wrap_p defaults low.
    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        one_shot_d = one_shot_q;
        halted_d   = halted_q;
        wrap_d     = 1'b0;
        if (restart) begin
            dir_d      = dir;
            one_shot_d = one_shot;
            state_d    = (dir == DIR_DOWN) ? ST_LAST : ST_FIRST;
            halted_d   = 1'b0;
        end else if (adv_s && tc_s) begin
            if (term_s && one_shot_q) begin
                // Stop on the terminal state instead of wrapping.
                halted_d = 1'b1;
            end else if (term_s) begin
                state_d = (dir_q == DIR_DOWN) ? ST_LAST : ST_FIRST;
                wrap_d  = 1'b1;
            end else if (dir_q == DIR_DOWN) begin
                state_d = state_q - SW'(1);
            end else begin
                state_d = state_q + SW'(1);
            end
        end else begin
            state_d = state_q;
        end
    end

    // State, latch and pulse registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_FIRST;
            dir_q      <= DIR_UP;
            one_shot_q <= 1'b0;
            halted_q   <= 1'b0;
            wrap_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            one_shot_q <= one_shot_d;
            halted_q   <= halted_d;
            wrap_q     <= wrap_d;
        end
    end

    assign state    = state_q;
    assign odd      = state_q[0];
    assign even     = ~state_q[0];
    assign terminal = term_s;
    assign wrap_p   = wrap_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_seq_fsm_n.sv
// ---------------------------------------------------------------------------
// tb_seq_fsm_n
// Three sequencers (N=3/DWELL=1, N=4/DWELL=3, N=5/DWELL=1) share one set of
// control inputs. A behavioural model of each is advanced every edge and all
// outputs are compared; directed steps add constant checks for key scenarios,
// followed by a randomised phase.
// ---------------------------------------------------------------------------
module tb_seq_fsm_n;

    logic clk = 1'b0;
    logic rst, pause, restart, dir, one_shot;

    logic [1:0] st3;
    logic [2:0] st4, st5;
    logic od3, ev3, tm3, wp3, hl3;
    logic od4, ev4, tm4, wp4, hl4;
    logic od5, ev5, tm5, wp5, hl5;

    int checks   = 0;
    int failures = 0;

    int nn [3] = '{3, 4, 5};
    int dd [3] = '{1, 3, 1};
    int ms [3];
    int mc [3];
    int md [3];
    int mo [3];
    int mh [3];
    int mw [3];

    always #5 clk = ~clk;

    seq_fsm_n #(.NUM_STATES(3), .DWELL(1)) u3 (
        .clk(clk), .rst(rst), .pause(pause), .restart(restart), .dir(dir),
        .one_shot(one_shot), .state(st3), .odd(od3), .even(ev3),
        .terminal(tm3), .wrap_p(wp3), .halted(hl3));

    seq_fsm_n #(.NUM_STATES(4), .DWELL(3)) u4 (
        .clk(clk), .rst(rst), .pause(pause), .restart(restart), .dir(dir),
        .one_shot(one_shot), .state(st4), .odd(od4), .even(ev4),
        .terminal(tm4), .wrap_p(wp4), .halted(hl4));

    seq_fsm_n #(.NUM_STATES(5), .DWELL(1)) u5 (
        .clk(clk), .rst(rst), .pause(pause), .restart(restart), .dir(dir),
        .one_shot(one_shot), .state(st5), .odd(od5), .even(ev5),
        .terminal(tm5), .wrap_p(wp5), .halted(hl5));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Model: state advances through 1..N with modular arithmetic.
    task automatic model_step();
        for (int k = 0; k < 3; k++) begin
            int n;
            int old;
            bit last;
            n = nn[k];
            if (rst) begin
                ms[k] = 1; mc[k] = 0; md[k] = 0; mo[k] = 0; mh[k] = 0; mw[k] = 0;
            end else if (restart) begin
                md[k] = int'(dir); mo[k] = int'(one_shot);
                ms[k] = dir ? n : 1;
                mc[k] = 0; mh[k] = 0; mw[k] = 0;
            end else if (pause || mh[k] != 0) begin
                mw[k] = 0;
            end else if (mc[k] < dd[k] - 1) begin
                mc[k]++;
                mw[k] = 0;
            end else begin
                mc[k] = 0;
                mw[k] = 0;
                old  = ms[k];
                last = (md[k] != 0) ? (old == 1) : (old == n);
                if (last && mo[k] != 0) begin
                    mh[k] = 1;
                end else begin
                    if (md[k] == 0) ms[k] = old % n + 1;
                    else            ms[k] = (old + n - 2) % n + 1;
                    mw[k] = last ? 1 : 0;
                end
            end
        end
    endtask

    task automatic cmp(input int k, input string nm, input logic [2:0] st,
                       input logic od, input logic ev, input logic tm,
                       input logic wp, input logic hl);
        int n;
        int term;
        n    = nn[k];
        term = (md[k] != 0) ? int'(ms[k] == 1) : int'(ms[k] == n);
        chk({nm, ".state"},    32'(st), 32'(ms[k]));
        chk({nm, ".odd"},      32'(od), 32'(ms[k] % 2));
        chk({nm, ".even"},     32'(ev), 32'(1 - ms[k] % 2));
        chk({nm, ".terminal"}, 32'(tm), 32'(term));
        chk({nm, ".wrap_p"},   32'(wp), 32'(mw[k]));
        chk({nm, ".halted"},   32'(hl), 32'(mh[k]));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cmp(0, "n3", {1'b0, st3}, od3, ev3, tm3, wp3, hl3);
        cmp(1, "n4", st4, od4, ev4, tm4, wp4, hl4);
        cmp(2, "n5", st5, od5, ev5, tm5, wp5, hl5);
    endtask

    task automatic set_in(input logic r, input logic rs, input logic pz,
                          input logic dr, input logic os);
        rst = r; restart = rs; pause = pz; dir = dr; one_shot = os;
    endtask

    int seen2;
    int exp_st3 [6] = '{2, 3, 1, 2, 3, 1};
    int exp_wp3 [6] = '{0, 0, 1, 0, 0, 1};

    initial begin
        set_in(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("rst.state", 32'(st3), 32'd1);
        chk("rst.odd",   32'(od3), 32'd1);
        chk("rst.even",  32'(ev3), 32'd0);
        chk("rst.term",  32'(tm3), 32'd0);

        // Free run N=3: 2,3,1,2,3,1 with wrap_p on each return to 1.
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("run.state", 32'(st3), 32'(exp_st3[i]));
            chk("run.wrap",  32'(wp3), 32'(exp_wp3[i]));
        end

        // Pause at state 3 for 4 cycles, then wrap on release.
        tick();
        tick();
        chk("pre_pause.state", 32'(st3), 32'd3);
        pause = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("pause.state", 32'(st3), 32'd3);
            chk("pause.term",  32'(tm3), 32'd1);
            chk("pause.wrap",  32'(wp3), 32'd0);
        end
        pause = 1'b0;
        tick();
        chk("unpause.state", 32'(st3), 32'd1);
        chk("unpause.wrap",  32'(wp3), 32'd1);

        // restart + pause at state 3; state held at 1 while restart high.
        tick();
        tick();
        chk("pre_rs.state", 32'(st3), 32'd3);
        set_in(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rs_hold.state", 32'(st3), 32'd1);
        end
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        chk("rs_rel.state", 32'(st3), 32'd2);

        // N=4 DWELL=3: pause 2 cycles after 2nd cycle of state 2 -> 5 cycles.
        restart = 1'b1;
        tick();
        restart = 1'b0;
        seen2 = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (st4 == 3'd2) seen2++;
        end
        pause = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            if (st4 == 3'd2) seen2++;
        end
        pause = 1'b0;
        tick();
        if (st4 == 3'd2) seen2++;
        tick();
        chk("dwell.next",   32'(st4), 32'd3);
        chk("dwell.cycles", 32'(seen2), 32'd5);

        // N=5 down one-shot: 5,4,3,2,1 then halt.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("os.start", 32'(st5), 32'd5);
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 4; i >= 1; i--) begin
            tick();
            chk("os.state", 32'(st5), 32'(i));
        end
        chk("os.term_at1", 32'(tm5), 32'd1);
        chk("os.not_yet",  32'(hl5), 32'd0);
        tick();
        chk("os.halted", 32'(hl5), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("os.hold",   32'(st5), 32'd1);
            chk("os.nowrap", 32'(wp5), 32'd0);
        end
        set_in(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        chk("os.clr_halt", 32'(hl5), 32'd0);
        chk("os.rs_state", 32'(st5), 32'd1);
        chk("os.rs_term",  32'(tm5), 32'd0);

        // Mid-sequence rst with restart high returns to up-count from 1.
        set_in(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        chk("mid.state", 32'(st5), 32'd3);
        set_in(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        chk("rstmid.state",  32'(st5), 32'd1);
        chk("rstmid.halted", 32'(hl5), 32'd0);
        chk("rstmid.wrap",   32'(wp5), 32'd0);
        set_in(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        chk("rstmid.up", 32'(st5), 32'd2);

        // Randomised phase against the model.
        for (int i = 0; i < 400; i++) begin
            set_in(($urandom_range(31) == 0),
                   ($urandom_range(15) == 0),
                   ($urandom_range(3) == 0),
                   1'($urandom_range(1)),
                   1'($urandom_range(1)));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_fsm_n.md
# seq_fsm_n

Parametrised step sequencer that generalises our fixed three-state odd/even FSM to NUM_STATES states. It adds a per-state dwell time, up/down direction, and a one-shot or wrap mode. It keeps the pause/restart control and the odd/even/terminal decode, so it drops into any control path that used the three-state FSM.

## Interface
- NUM_STATES, default 3: number of sequence states, ≥2; state values are 1..NUM_STATES.
- DWELL, default 1: clock cycles spent in each state, ≥1.
- SW, default $clog2(NUM_STATES+1): state output width (derived, do not override).
- clk  in  1  sole clock, all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- pause  in  1  freeze state and dwell count while high.
- restart  in  1  synchronous return to the start state; overrides pause.
- dir  in  1  0 = count up, 1 = count down; sampled only when restart is high.
- one_shot  in  1  1 = halt at terminal, 0 = wrap; sampled only when restart is high.
- state  out  SW  current state index, 1-based.
- odd  out  1  state[0].
- even  out  1  ~state[0].
- terminal  out  1  state is the last state in the latched direction (NUM_STATES when up, 1 when down).
- wrap_p  out  1  one-cycle pulse on the first cycle after a wrap.
- halted  out  1  one-shot sequence has completed.

## Operation
- Registers: state, dwell_cnt, dir_q, one_shot_q, halted, wrap_p.
- Reset values: state=1, dwell_cnt=0, dir_q=0, one_shot_q=0, halted=0, wrap_p=0. The decoded outputs therefore reset to odd=1, even=0, terminal=0.
- Priority, evaluated per edge: rst > restart > pause > halted > advance.
- restart:
  - dir_q←dir, one_shot_q←one_shot.
  - state←1 if dir=0, else NUM_STATES.
  - dwell_cnt←0, halted←0, wrap_p←0.
  - While restart stays high, state holds at the start state.
- pause with no restart: every register holds, except wrap_p, which clears.
- halted=1: all registers hold until restart or rst.
- Advance:
  - If dwell_cnt < DWELL-1, dwell_cnt increments.
  - Otherwise dwell_cnt←0 and a step event occurs.
- Step event, up: state+1. At NUM_STATES, wrap to 1 with wrap_p←1.
- Step event, down: state-1. At 1, wrap to NUM_STATES with wrap_p←1.
- Step event at terminal with one_shot_q=1: state holds, halted←1, no wrap_p.
- wrap_p is 0 on every edge that is not a wrapping step event.
- Outputs are Moore decodes of registered state only: no combinational path from any input to any output.

## Timing
- Every control input takes effect on the next rising edge; there is no multi-cycle latency.
- A new state is visible from the edge that performs the step.
- Each state is held exactly DWELL cycles in free run.
- Pausing mid-dwell preserves dwell_cnt, so total dwell excluding paused cycles is still DWELL.
- restart and pause asserted on the same edge: restart wins.
- rst mid-sequence, including while restart or pause is high: reset values on the next edge; direction returns to up.
- A dir or one_shot change without restart has no effect.
- DWELL=1: a step occurs every unpaused cycle and dwell_cnt stays 0.

## Structure
- Package seq_fsm_pkg holds:
  - dir constants DIR_UP=1'b0 and DIR_DOWN=1'b1;
  - a width helper function for SW and the dwell counter width, $clog2(DWELL) with a minimum of 1.
- Sub-module dwell_counter contains the DWELL-cycle counter:
  - ports: clk, rst, clr, en, step;
  - clr has priority over en;
  - step is a combinational terminal-count flag.
- seq_fsm_n contains the state register, direction/mode latches, the wrap/halt logic and the output decode.

## Test plan
- N=3, DWELL=1, rst high then low → state 1(odd),2(even),3(odd, terminal),1, with wrap_p=1 only on the return to 1; repeats with period 3.
- N=3, pause held 4 cycles while state=3 → state stays 3, terminal stays 1, wrap_p=0; after release the next edge gives state 1 with wrap_p=1.
- restart=1 with pause=1 while state=3 → state=1 on the next edge and held for 2 cycles while restart stays high; after release, state 2 one edge later.
- N=4, DWELL=3, pause for 2 cycles after the 2nd cycle of state 2 → state 2 visible for 5 cycles total, then state 3.
- N=5, DWELL=1, restart with dir=1 and one_shot=1 → 5,4,3,2,1; at 1 terminal=1, then halted=1 on the next edge; state stays 1 for 10 cycles with wrap_p never asserted; restart with dir=0 clears halted and gives state=1, terminal=0.
- Mid-sequence (N=5, down, state=3), rst=1 with restart=1 → state=1, halted=0, wrap_p=0; after rst low the count goes up: state 2 next edge.
